// File: rtl/mem_log_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_log_ctrl_if
//   Bundles every handshake and bus signal around mem_log_ctrl. The signal
//   names follow the controller's own port list, so the i_/o_ prefixes read
//   from the controller's point of view.
//
//   Command channel : i_cmd_valid, i_cmd, o_cmd_ready
//   Status          : o_busy, o_log_done, o_timeout
//   mem_log side    : o_log_run, o_log_read, o_log_addr, i_log_full, i_log_data
//   Readback stream : o_dat_valid, o_dat, i_dat_ready
//
//   modport master : the sequencer (mem_log_ctrl) itself
//   modport slave  : everything around it (decoder, mem_log, stream sink)
// ---------------------------------------------------------------------------
interface mem_log_ctrl_if #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_NBIT = 3
);

  logic                     i_cmd_valid;
  logic [1:0]               i_cmd;
  logic                     o_cmd_ready;
  logic                     o_busy;
  logic                     o_log_done;
  logic                     o_timeout;
  logic                     o_log_run;
  logic                     o_log_read;
  logic [RAM_ADDR_NBIT-1:0] o_log_addr;
  logic                     i_log_full;
  logic [RAM_WIDTH-1:0]     i_log_data;
  logic                     o_dat_valid;
  logic [RAM_WIDTH-1:0]     o_dat;
  logic                     i_dat_ready;

  modport master (
    input  i_cmd_valid, i_cmd, i_log_full, i_log_data, i_dat_ready,
    output o_cmd_ready, o_busy, o_log_done, o_timeout,
           o_log_run, o_log_read, o_log_addr, o_dat_valid, o_dat
  );

  modport slave (
    output i_cmd_valid, i_cmd, i_log_full, i_log_data, i_dat_ready,
    input  o_cmd_ready, o_busy, o_log_done, o_timeout,
           o_log_run, o_log_read, o_log_addr, o_dat_valid, o_dat
  );

endinterface

// File: rtl/mem_log_ctrl.sv
// ---------------------------------------------------------------------------
// mem_log_ctrl
//   Sequencer for the mem_log capture buffer. A START command arms a capture
//   with a one-cycle run pulse, then waits for mem_log to report full (or for
//   the watchdog to expire). A DUMP command afterwards walks all 2**RAM_ADDR_NBIT
//   words in ascending order and presents each one on a valid/ready stream.
//   ABORT is honoured in every state and returns the block to IDLE.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   bus (master)      : command channel, status flags, mem_log control and
//                       data, readback stream (see mem_log_ctrl_if)
//
// Parameters
//   RAM_WIDTH         : mem_log word width
//   RAM_ADDR_NBIT     : mem_log address width, depth N = 2**RAM_ADDR_NBIT
//   RD_LAT            : cycles from address change to valid read data (1..3)
//   TIMEOUT_NBIT      : watchdog width, capture gives up after 2**n-1 cycles
// ---------------------------------------------------------------------------
module mem_log_ctrl #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_NBIT = 3,
  parameter int RD_LAT        = 1,
  parameter int TIMEOUT_NBIT  = 16
) (
  input logic            clk,
  input logic            rst,
  mem_log_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DONE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_SEND
  } state_t;

  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DUMP  = 2'd2;
  localparam logic [1:0] CMD_ABORT = 2'd3;

  // RD_WAIT lasts RD_LAT cycles; the wait counter runs 0..RD_LAT-1.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t                   state_q, state_n;
  logic [RAM_ADDR_NBIT-1:0] idx_q, idx_n;
  logic [TIMEOUT_NBIT-1:0]  wdog_q, wdog_n, wdog_inc;
  logic [1:0]               wait_q, wait_n;
  logic [RAM_WIDTH-1:0]     dat_q, dat_n;
  logic                     done_q, done_n;
  logic                     timeout_q, timeout_n;
  logic                     abort_cmd;
  logic                     accepting;

  // Decode the two conditions every state cares about: whether the block is
  // idle enough to take a command, and whether an ABORT is being presented
  // (ABORT does not need o_cmd_ready).
  always_comb begin
    accepting = (state_q == S_IDLE) || (state_q == S_DONE);
    abort_cmd = bus.i_cmd_valid && (bus.i_cmd == CMD_ABORT);
  end

  // State and datapath registers. Reset puts everything back to an empty,
  // idle controller so no half-sent stream word or stale flag survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wdog_q    <= '0;
      wait_q    <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      wdog_q    <= wdog_n;
      wait_q    <= wait_n;
      dat_q     <= dat_n;
      done_q    <= done_n;
      timeout_q <= timeout_n;
    end
  end

  // Next-state and next-datapath logic. Every register holds by default;
  // ABORT is checked ahead of the per-state behaviour so it wins over full,
  // timeout and stream handshakes alike. The read index only ever leaves
  // zero inside the dump states and is put back to zero on the way out, so
  // o_log_addr reads 0 whenever no dump is in progress.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    wdog_n    = wdog_q;
    wait_n    = wait_q;
    dat_n     = dat_q;
    done_n    = done_q;
    timeout_n = timeout_q;
    wdog_inc  = wdog_q + TIMEOUT_NBIT'(1);

    if (abort_cmd) begin
      state_n = S_IDLE;
      idx_n   = '0;
      wdog_n  = '0;
      wait_n  = '0;
      done_n  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.i_cmd_valid) begin
            if (bus.i_cmd == CMD_START) begin
              state_n   = S_ARM;
              done_n    = 1'b0;
              timeout_n = 1'b0;
            end else if ((bus.i_cmd == CMD_DUMP) && done_q) begin
              state_n = S_RD_ADDR;
              idx_n   = '0;
            end
          end
        end

        S_ARM: begin
          wdog_n  = '0;
          state_n = S_CAPTURE;
        end

        // The watchdog gives up on the cycle it would reach all-ones, which
        // makes the capture window exactly 2**TIMEOUT_NBIT-1 cycles long.
        // A full seen on that same cycle still counts as a good capture.
        S_CAPTURE: begin
          wdog_n = wdog_inc;
          if (bus.i_log_full) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else if (&wdog_inc) begin
            state_n   = S_IDLE;
            timeout_n = 1'b1;
          end
        end

        S_RD_ADDR: begin
          wait_n  = '0;
          state_n = S_RD_WAIT;
        end

        // Address has been stable since RD_ADDR; after RD_LAT cycles here
        // mem_log's output belongs to it and is latched into the stream reg.
        S_RD_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            dat_n   = bus.i_log_data;
            state_n = S_SEND;
          end else begin
            wait_n = wait_q + 2'd1;
          end
        end

        // The last word is recognised by the index being all-ones; that is
        // the only place the index wraps back to zero.
        S_SEND: begin
          if (bus.i_dat_ready) begin
            if (&idx_q) begin
              idx_n   = '0;
              state_n = S_DONE;
            end else begin
              idx_n   = idx_q + RAM_ADDR_NBIT'(1);
              state_n = S_RD_ADDR;
            end
          end
        end

        default: begin
          state_n = S_IDLE;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the registered state, so run/read/valid
  // never glitch on command inputs. o_dat only changes when a new word is
  // latched in RD_WAIT, which keeps it stable across a stalled SEND.
  assign bus.o_cmd_ready = accepting;
  assign bus.o_busy      = !accepting;
  assign bus.o_log_run   = (state_q == S_ARM);
  assign bus.o_log_read  = (state_q == S_RD_ADDR) || (state_q == S_RD_WAIT) ||
                           (state_q == S_SEND);
  assign bus.o_log_addr  = idx_q;
  assign bus.o_dat_valid = (state_q == S_SEND);
  assign bus.o_dat       = dat_q;
  assign bus.o_log_done  = done_q;
  assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_log_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_log_ctrl
//   Self-checking bench for mem_log_ctrl with a behavioural mem_log model:
//   depth 8, one-cycle read latency, word at address a reads as a*3, and a
//   full flag raised a programmable number of cycles after each run pulse.
//   A 4-bit watchdog keeps the timeout case short (15 capture cycles).
// ---------------------------------------------------------------------------
module tb_mem_log_ctrl;

  localparam int RAM_WIDTH      = 32;
  localparam int ADDR_NBIT      = 3;
  localparam int N              = 8;
  localparam int TOUT_NBIT      = 4;
  localparam int TIMEOUT_CYCLES = (2 ** TOUT_NBIT) - 1;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DUMP  = 2'd2;
  localparam logic [1:0] CMD_ABORT = 2'd3;

  logic clk;
  logic rst;

  int checks     = 0;
  int failures   = 0;
  int run_cycles = 0;
  int full_delay = 12;
  bit full_enable = 1'b1;

  mem_log_ctrl_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_ADDR_NBIT(ADDR_NBIT)) bus ();

  mem_log_ctrl #(
    .RAM_WIDTH    (RAM_WIDTH),
    .RAM_ADDR_NBIT(ADDR_NBIT),
    .RD_LAT       (1),
    .TIMEOUT_NBIT (TOUT_NBIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mem_log: the read port returns addr*3 one cycle after the
  // address is presented, and full rises full_delay cycles after a run pulse
  // (never, when full_enable is clear). Each run pulse also clears full.
  initial begin : mem_model
    int cnt;
    bit armed;
    logic [ADDR_NBIT-1:0] last_addr;
    cnt = 0;
    armed = 1'b0;
    last_addr = '0;
    bus.i_log_full = 1'b0;
    bus.i_log_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_log_data = 32'(last_addr) * 32'd3;
      last_addr = bus.o_log_addr;
      if (bus.o_log_run === 1'b1) begin
        run_cycles++;
        bus.i_log_full = 1'b0;
        cnt = full_delay;
        armed = full_enable;
      end else if (armed) begin
        cnt--;
        if (cnt == 0) begin
          bus.i_log_full = 1'b1;
          armed = 1'b0;
        end
      end
    end
  end

  initial begin : global_guard
    #2000000;
    $display("[TB] FAIL global_timeout simulation did not finish observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] cmd);
    bus.i_cmd_valid = valid;
    bus.i_cmd       = cmd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue START and follow the capture to its end. The capture is expected
  // to finish (o_busy low) one cycle after full is sampled, or after the
  // full watchdog window when the model never raises full.
  task automatic runCapture(input int delay, input bit never);
    int base;
    int c;
    int expect_c;
    full_delay  = delay;
    full_enable = !never;
    base = run_cycles;
    applyStimulus(1'b1, CMD_START);
    nextCycle;
    applyStimulus(1'b0, CMD_NOP);
    checkOutput("arm_run", 32'(bus.o_log_run), 32'd1);
    checkOutput("arm_busy", 32'(bus.o_busy), 32'd1);
    checkOutput("arm_done_clr", 32'(bus.o_log_done), 32'd0);
    checkOutput("arm_tout_clr", 32'(bus.o_timeout), 32'd0);
    checkOutput("arm_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
    c = 0;
    while ((bus.o_busy === 1'b1) && (c < 40)) begin
      nextCycle;
      c++;
    end
    expect_c = never ? (TIMEOUT_CYCLES + 1) : (delay + 1);
    checkOutput("cap_len", 32'(c), 32'(expect_c));
    checkOutput("cap_done", 32'(bus.o_log_done), never ? 32'd0 : 32'd1);
    checkOutput("cap_timeout", 32'(bus.o_timeout), never ? 32'd1 : 32'd0);
    checkOutput("cap_run_pulses", 32'(run_cycles - base), 32'd1);
    checkOutput("cap_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
  endtask

  // Issue DUMP and collect the stream. The scoreboard expects beats k*3 in
  // order, exactly N of them, with o_dat frozen across any stalled cycle.
  task automatic runDump(input bit rand_ready, input bit inject_start);
    int beats;
    int base;
    bit stalled;
    logic [31:0] held;
    beats = 0;
    stalled = 1'b0;
    held = '0;
    base = run_cycles;
    applyStimulus(1'b1, CMD_DUMP);
    nextCycle;
    for (int cyc = 0; (cyc < 200) && (beats < N); cyc++) begin
      if (inject_start && (cyc == 4)) applyStimulus(1'b1, CMD_START);
      else applyStimulus(1'b0, CMD_NOP);
      bus.i_dat_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      checkOutput("dump_read", 32'(bus.o_log_read), 32'd1);
      if (stalled) begin
        checkOutput("stall_valid", 32'(bus.o_dat_valid), 32'd1);
        checkOutput("stall_hold", bus.o_dat, held);
      end
      if ((bus.o_dat_valid === 1'b1) && bus.i_dat_ready) begin
        checkOutput("beat_data", bus.o_dat, 32'(beats * 3));
        checkOutput("beat_addr", 32'(bus.o_log_addr), 32'(beats));
        if (!rand_ready) checkOutput("beat_time", 32'(cyc), 32'(3 * beats + 2));
        beats++;
        stalled = 1'b0;
      end else if (bus.o_dat_valid === 1'b1) begin
        stalled = 1'b1;
        held = bus.o_dat;
      end else begin
        stalled = 1'b0;
      end
      nextCycle;
    end
    applyStimulus(1'b0, CMD_NOP);
    checkOutput("dump_beats", 32'(beats), 32'(N));
    checkOutput("dump_end_valid", 32'(bus.o_dat_valid), 32'd0);
    checkOutput("dump_end_read", 32'(bus.o_log_read), 32'd0);
    checkOutput("dump_end_addr", 32'(bus.o_log_addr), 32'd0);
    checkOutput("dump_end_done", 32'(bus.o_log_done), 32'd1);
    checkOutput("dump_end_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("dump_no_run", 32'(run_cycles - base), 32'd0);
  endtask

  // Dump three words, stall on the fourth, then ABORT it.
  task automatic abortDump;
    int beats;
    bit found;
    beats = 0;
    found = 1'b0;
    applyStimulus(1'b1, CMD_DUMP);
    nextCycle;
    applyStimulus(1'b0, CMD_NOP);
    for (int cyc = 0; (cyc < 100) && !found; cyc++) begin
      bus.i_dat_ready = (beats < 3);
      if ((bus.o_dat_valid === 1'b1) && (beats == 3)) begin
        found = 1'b1;
      end else begin
        if ((bus.o_dat_valid === 1'b1) && bus.i_dat_ready) beats++;
        nextCycle;
      end
    end
    checkOutput("abort_reach_beat4", 32'(found), 32'd1);
    checkOutput("abort_beat4_data", bus.o_dat, 32'd9);
    nextCycle;
    checkOutput("abort_stall_valid", 32'(bus.o_dat_valid), 32'd1);
    applyStimulus(1'b1, CMD_ABORT);
    nextCycle;
    applyStimulus(1'b0, CMD_NOP);
    checkOutput("abort_valid", 32'(bus.o_dat_valid), 32'd0);
    checkOutput("abort_read", 32'(bus.o_log_read), 32'd0);
    checkOutput("abort_addr", 32'(bus.o_log_addr), 32'd0);
    checkOutput("abort_done", 32'(bus.o_log_done), 32'd0);
    checkOutput("abort_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("abort_timeout_kept", 32'(bus.o_timeout), 32'd0);
  endtask

  // Directed sequence of scenarios; random full delays and ready patterns
  // come from $urandom.
  initial begin : main
    rst = 1'b1;
    applyStimulus(1'b0, CMD_NOP);
    bus.i_dat_ready = 1'b0;
    nextCycle;
    nextCycle;
    checkOutput("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_done", 32'(bus.o_log_done), 32'd0);
    checkOutput("rst_timeout", 32'(bus.o_timeout), 32'd0);
    checkOutput("rst_run", 32'(bus.o_log_run), 32'd0);
    checkOutput("rst_read", 32'(bus.o_log_read), 32'd0);
    checkOutput("rst_addr", 32'(bus.o_log_addr), 32'd0);
    checkOutput("rst_valid", 32'(bus.o_dat_valid), 32'd0);
    checkOutput("rst_dat", bus.o_dat, 32'd0);
    rst = 1'b0;
    nextCycle;

    // DUMP before any capture has nothing to send
    applyStimulus(1'b1, CMD_DUMP);
    nextCycle;
    applyStimulus(1'b0, CMD_NOP);
    checkOutput("early_dump_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("early_dump_read", 32'(bus.o_log_read), 32'd0);

    runCapture(12, 1'b0);
    runDump(1'b0, 1'b0);
    runDump(1'b0, 1'b0);
    runDump(1'b1, 1'b1);

    // full on the last cycle of the watchdog window still wins
    runCapture(TIMEOUT_CYCLES, 1'b0);

    // watchdog expiry, then DUMP ignored and ABORT leaves o_timeout alone
    runCapture(0, 1'b1);
    applyStimulus(1'b1, CMD_DUMP);
    nextCycle;
    applyStimulus(1'b0, CMD_NOP);
    checkOutput("tout_dump_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("tout_dump_read", 32'(bus.o_log_read), 32'd0);
    checkOutput("tout_done", 32'(bus.o_log_done), 32'd0);
    applyStimulus(1'b1, CMD_ABORT);
    nextCycle;
    applyStimulus(1'b0, CMD_NOP);
    checkOutput("tout_abort_kept", 32'(bus.o_timeout), 32'd1);

    runCapture(int'($urandom_range(12, 1)), 1'b0);
    abortDump();
    runCapture(int'($urandom_range(12, 1)), 1'b0);
    runDump(1'b1, 1'b0);

    // reset in the middle of a stalled word
    applyStimulus(1'b1, CMD_DUMP);
    bus.i_dat_ready = 1'b0;
    nextCycle;
    applyStimulus(1'b0, CMD_NOP);
    nextCycle;
    nextCycle;
    checkOutput("mid_valid_before_rst", 32'(bus.o_dat_valid), 32'd1);
    rst = 1'b1;
    nextCycle;
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(bus.o_dat_valid), 32'd0);
    checkOutput("mid_rst_read", 32'(bus.o_log_read), 32'd0);
    checkOutput("mid_rst_addr", 32'(bus.o_log_addr), 32'd0);
    checkOutput("mid_rst_done", 32'(bus.o_log_done), 32'd0);
    checkOutput("mid_rst_dat", bus.o_dat, 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
